sc_fifo_burst_reader: RTL and testbench

//  Downstream drain stage for generic_sc_fifo (show-ahead read: data valid while !empty, rd_en pops).

---
 rtl/sc_fifo_burst_reader_pkg.sv | 17 +
 rtl/sc_fifo_burst_reader_skid.sv | 60 ++++++
 rtl/sc_fifo_burst_reader.sv | 143 ++++++++++++++
 tb/tb_sc_fifo_burst_reader.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_fifo_burst_reader_pkg.sv
// Shared types and helpers for the FIFO burst reader.
package sc_fifo_burst_reader_pkg;

    typedef enum logic {
        RD_IDLE,
        RD_BURST
    } rd_state_t;

    // Counter width that can hold values 0..value-1, never narrower than one bit.
    function automatic int width_min1(input int value);
        if (value < 2) begin
            return 1;
        end
        return $clog2(value);
    endfunction

endpackage

// File: rtl/sc_fifo_burst_reader_skid.sv
// Two-entry registered valid/ready buffer. The head register drives the
// outputs directly; the spare register absorbs one beat while the sink stalls.
module stream_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    output logic         valid,
    input  logic         ready,
    output logic [W-1:0] data,
    output logic [1:0]   occ
);

    logic [W-1:0] head_q;
    logic [W-1:0] spare_q;
    logic [1:0]   occ_q;
    logic         pop;

    assign pop   = (occ_q != 2'd0) && ready;
    assign valid = (occ_q != 2'd0);
    assign data  = head_q;
    assign occ   = occ_q;

    // Head/spare shuffle; a simultaneous push and pop keeps occupancy and order.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            spare_q <= '0;
            occ_q   <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        head_q <= push_data;
                        occ_q  <= occ_q + 2'd1;
                    end else if (occ_q == 2'd1) begin
                        spare_q <= push_data;
                        occ_q   <= occ_q + 2'd1;
                    end
                end
                2'b01: begin
                    head_q <= spare_q;
                    occ_q  <= occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        head_q <= push_data;
                    end else begin
                        head_q  <= spare_q;
                        spare_q <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sc_fifo_burst_reader.sv
// Drains a show-ahead FIFO in bursts and frames them with sop/eop on a
// registered valid/ready stream. Short bursts are flushed after a timeout.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RD_IDLE  | wait for a full burst in the FIFO or for the idle timeout
// RD_BURST | pop len words into the skid buffer, hold while FIFO empty
module sc_fifo_burst_reader
    import sc_fifo_burst_reader_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 256,
    parameter int BURST_LEN = 16,
    parameter int TIMEOUT   = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              fifo_rd_en_o,
    input  logic [DATA_W-1:0] fifo_data_i,
    input  logic [ADDR_W:0]   fifo_usedw_i,
    input  logic              fifo_empty_i,
    output logic              src_valid_o,
    input  logic              src_ready_i,
    output logic [DATA_W-1:0] src_data_o,
    output logic              src_sop_o,
    output logic              src_eop_o
);

    localparam int LEN_W = width_min1(BURST_LEN + 1);
    localparam int TMR_W = width_min1(TIMEOUT + 1);

    localparam logic [ADDR_W:0]  BURST_THRESH = (ADDR_W + 1)'(BURST_LEN);
    localparam logic [LEN_W-1:0] BURST_LEN_L  = LEN_W'(BURST_LEN);
    localparam logic [LEN_W-1:0] LEN_ONE      = LEN_W'(1);
    localparam logic [TMR_W-1:0] TMR_ONE      = TMR_W'(1);
    localparam logic [TMR_W-1:0] TMR_MAX      = '1;
    localparam logic [TMR_W-1:0] TMR_LAST     = TMR_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam bit               TIMEOUT_EN   = (TIMEOUT != 0);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
    } beat_t;

    rd_state_t        state_q;
    rd_state_t        state_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_d;
    logic [LEN_W-1:0] beat_q;
    logic [TMR_W-1:0] timer_q;
    logic             rd_en;
    logic             last_pop;
    logic [1:0]       occ;
    beat_t            push_beat;
    beat_t            out_beat;
    logic             out_valid;

    // Next-state, burst length capture and the pop strobe (registered inputs only).
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        rd_en    = 1'b0;
        last_pop = 1'b0;
        case (state_q)
            RD_IDLE: begin
                if (fifo_usedw_i >= BURST_THRESH) begin
                    state_d = RD_BURST;
                    len_d   = BURST_LEN_L;
                end else if (TIMEOUT_EN && !fifo_empty_i && (timer_q == TMR_LAST)) begin
                    state_d = RD_BURST;
                    len_d   = LEN_W'(fifo_usedw_i);
                end
            end
            RD_BURST: begin
                rd_en    = !fifo_empty_i && (occ < 2'd2);
                last_pop = rd_en && (beat_q == (len_q - LEN_ONE));
                if (last_pop) begin
                    state_d = RD_IDLE;
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    // State register and latched burst length.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RD_IDLE;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
        end
    end

    // Beat counter within the current burst; cleared on the closing pop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beat_q <= '0;
        end else if (last_pop) begin
            beat_q <= '0;
        end else if (rd_en) begin
            beat_q <= beat_q + LEN_ONE;
        end
    end

    // Idle timer counts non-empty IDLE cycles and saturates; cleared otherwise.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            timer_q <= '0;
        end else if ((state_q != RD_IDLE) || (state_d != RD_IDLE) || fifo_empty_i) begin
            timer_q <= '0;
        end else if (timer_q != TMR_MAX) begin
            timer_q <= timer_q + TMR_ONE;
        end
    end

    assign push_beat.data = fifo_data_i;
    assign push_beat.sop  = (beat_q == '0);
    assign push_beat.eop  = last_pop;

    stream_skid_buf #(
        .W ($bits(beat_t))
    ) u_skid (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (rd_en),
        .push_data (push_beat),
        .valid     (out_valid),
        .ready     (src_ready_i),
        .data      (out_beat),
        .occ       (occ)
    );

    // Framing flags are qualified by valid so stale head contents never show.
    assign fifo_rd_en_o = rd_en;
    assign src_valid_o  = out_valid;
    assign src_data_o   = out_beat.data;
    assign src_sop_o    = out_valid && out_beat.sop;
    assign src_eop_o    = out_valid && out_beat.eop;

endmodule

// File: tb/tb_sc_fifo_burst_reader.sv
// Bench for sc_fifo_burst_reader fed by a small show-ahead FIFO model.
module tb_sc_fifo_burst_reader;

    localparam int ADDR_W    = 4;
    localparam int DATA_W    = 16;
    localparam int BURST_LEN = 4;
    localparam int TIMEOUT   = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              fifo_rst;
    logic              rd_en;
    logic [DATA_W-1:0] fifo_data;
    logic [ADDR_W:0]   fifo_usedw;
    logic              fifo_empty;
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              usedw_force;

    logic [DATA_W-1:0] mem [16];
    logic [ADDR_W-1:0] wp, rp;
    logic [ADDR_W:0]   cnt;
    logic              do_wr, do_rd;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_pops   = 0;

    logic [DATA_W-1:0] bd [$];
    logic              bs [$];
    logic              be [$];
    int                bc [$];

    logic              prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data;
    logic              prev_sop, prev_eop;

    always #5 clk = ~clk;

    sc_fifo_burst_reader #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .BURST_LEN (BURST_LEN),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .fifo_rd_en_o (rd_en),
        .fifo_data_i  (fifo_data),
        .fifo_usedw_i (fifo_usedw),
        .fifo_empty_i (fifo_empty),
        .src_valid_o  (valid),
        .src_ready_i  (ready),
        .src_data_o   (data),
        .src_sop_o    (sop),
        .src_eop_o    (eop)
    );

    // Show-ahead FIFO model, 16 deep.
    assign do_wr      = wr_en && (cnt < 5'd16);
    assign do_rd      = rd_en && (cnt != 5'd0);
    assign fifo_data  = mem[rp];
    assign fifo_empty = (cnt == 5'd0);
    assign fifo_usedw = usedw_force ? 5'd4 : cnt;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_wr) begin
                mem[wp] <= wr_data;
                wp      <= wp + 1'b1;
            end
            if (do_rd) rp <= rp + 1'b1;
            cnt <= cnt + {4'd0, do_wr} - {4'd0, do_rd};
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_beats();
        bd.delete();
        bs.delete();
        be.delete();
        bc.delete();
    endtask

    // Monitor: underflow guard, stall stability, and capture of accepted beats.
    always @(negedge clk) begin
        chk("no_underflow", int'(rd_en && fifo_empty), 0);
        if (!rst && prev_stall) begin
            chk("stall_valid", int'(valid), 1);
            chk("stall_data", int'(data), int'(prev_data));
            chk("stall_sop", int'(sop), int'(prev_sop));
            chk("stall_eop", int'(eop), int'(prev_eop));
        end
        prev_stall = !rst && valid && !ready;
        prev_data  = data;
        prev_sop   = sop;
        prev_eop   = eop;
        if (rd_en) n_pops++;
        if (!rst && valid && ready) begin
            bd.push_back(data);
            bs.push_back(sop);
            be.push_back(eop);
            bc.push_back(cyc);
        end
    end

    // n words written back to back; mode 0 ready=1, 1 ready toggles, 2 ready=0 for 20 clks.
    // lat/last_at: cycle offsets from first write to first/last accepted beat (0 = not checked).
    typedef struct packed {
        int n;
        int base;
        int mode;
        int l0;
        int l1;
        int l2;
        int l3;
        int lat;
        int last_at;
    } vec_t;

    vec_t vecs [7];

    initial begin
        // Threshold path: usedw=4 at c+4, BURST c+5, first beat c+6.
        // Timeout path: empty drops at c+1, timer hits 7 at c+8, pop c+9, beat c+10.
        vecs[0] = '{4,  'h0A0, 0, 4, 0, 0, 0, 6,  9};
        vecs[1] = '{10, 'h0B0, 0, 4, 4, 2, 0, 6,  24};
        vecs[2] = '{1,  'h0C0, 0, 1, 0, 0, 0, 10, 10};
        vecs[3] = '{3,  'h0D0, 0, 3, 0, 0, 0, 10, 12};
        vecs[4] = '{16, 'h100, 1, 4, 4, 4, 4, 0,  0};
        vecs[5] = '{16, 'h200, 2, 4, 4, 4, 4, 0,  0};
        vecs[6] = '{5,  'h300, 0, 4, 1, 0, 0, 6,  18};

        rst = 1'b1; fifo_rst = 1'b1; wr_en = 1'b0; wr_data = '0;
        ready = 1'b0; usedw_force = 1'b0;
        repeat (3) tick();
        chk("reset_valid", int'(valid), 0);
        chk("reset_rd_en", int'(rd_en), 0);
        chk("reset_sop", int'(sop), 0);
        chk("reset_eop", int'(eop), 0);
        chk("reset_data", int'(data), 0);
        rst = 1'b0; fifo_rst = 1'b0;
        tick();

        for (int v = 0; v < 7; v++) begin
            int lens [4];
            int esop [32];
            int eeop [32];
            int idx;
            int k;
            int t0;
            lens[0] = vecs[v].l0; lens[1] = vecs[v].l1;
            lens[2] = vecs[v].l2; lens[3] = vecs[v].l3;
            idx = 0;
            for (int b = 0; b < 4; b++) begin
                for (int j = 0; j < lens[b]; j++) begin
                    esop[idx] = (j == 0) ? 1 : 0;
                    eeop[idx] = (j == lens[b] - 1) ? 1 : 0;
                    idx++;
                end
            end
            clear_beats();
            t0 = cyc;
            k  = 0;
            while (k < 300 && !(k >= vecs[v].n && bd.size() == vecs[v].n)) begin
                wr_en   = (k < vecs[v].n);
                wr_data = DATA_W'(vecs[v].base + k);
                case (vecs[v].mode)
                    0:       ready = 1'b1;
                    1:       ready = (k % 2 == 0);
                    default: ready = (k >= 20);
                endcase
                tick();
                k++;
            end
            wr_en = 1'b0;
            ready = 1'b1;
            chk($sformatf("v%0d_beat_count", v), bd.size(), vecs[v].n);
            repeat (12) tick();
            chk($sformatf("v%0d_no_extra", v), bd.size(), vecs[v].n);
            for (int i = 0; i < bd.size() && i < vecs[v].n; i++) begin
                chk($sformatf("v%0d_data%0d", v, i), int'(bd[i]), vecs[v].base + i);
                chk($sformatf("v%0d_sop%0d", v, i), int'(bs[i]), esop[i]);
                chk($sformatf("v%0d_eop%0d", v, i), int'(be[i]), eeop[i]);
            end
            if (vecs[v].lat != 0 && bd.size() == vecs[v].n) begin
                chk($sformatf("v%0d_first_lat", v), bc[0] - t0, vecs[v].lat);
                chk($sformatf("v%0d_last_at", v), bc[vecs[v].n - 1] - t0, vecs[v].last_at);
            end
        end

        // Upstream stall mid-burst: usedw briefly reports 4 with 3 words stored.
        begin
            int t0;
            clear_beats();
            ready = 1'b1;
            t0 = cyc;
            for (int i = 0; i < 3; i++) begin
                wr_en = 1'b1; wr_data = DATA_W'('h500 + i);
                tick();
            end
            wr_en = 1'b0;
            usedw_force = 1'b1;
            tick();
            usedw_force = 1'b0;
            repeat (16) tick();
            chk("stall_beats", bd.size(), 3);
            chk("stall_no_rd", int'(rd_en), 0);
            if (bd.size() == 3) begin
                chk("stall_sop0", int'(bs[0]), 1);
                chk("stall_eop2", int'(be[2]), 0);
            end
            wr_en = 1'b1; wr_data = DATA_W'('h503);
            tick();
            wr_en = 1'b0;
            repeat (8) tick();
            chk("stall_total", bd.size(), 4);
            if (bd.size() == 4) begin
                chk("stall_data3", int'(bd[3]), 'h503);
                chk("stall_sop3", int'(bs[3]), 0);
                chk("stall_eop3", int'(be[3]), 1);
                chk("stall_last_at", bc[3] - t0, 22);
            end
        end

        // Reset mid-burst with the skid buffer full and ready low.
        begin
            int t0;
            clear_beats();
            ready  = 1'b0;
            n_pops = 0;
            t0 = cyc;
            for (int i = 0; i < 4; i++) begin
                wr_en = 1'b1; wr_data = DATA_W'('h600 + i);
                tick();
            end
            wr_en = 1'b0;
            repeat (6) tick();
            chk("full_pops", n_pops, 2);
            chk("full_rd_en", int'(rd_en), 0);
            chk("full_valid", int'(valid), 1);
            chk("full_data", int'(data), 'h600);
            chk("full_sop", int'(sop), 1);
            chk("full_left", int'(fifo_usedw), 2);
            rst = 1'b1;
            tick();
            rst = 1'b0;
            chk("mid_rst_valid", int'(valid), 0);
            chk("mid_rst_rd_en", int'(rd_en), 0);
            chk("mid_rst_data", int'(data), 0);
            chk("mid_rst_sop", int'(sop), 0);
            chk("mid_rst_eop", int'(eop), 0);
            ready = 1'b1;
            repeat (14) tick();
            chk("left_beats", bd.size(), 2);
            if (bd.size() == 2) begin
                chk("left_data0", int'(bd[0]), 'h602);
                chk("left_data1", int'(bd[1]), 'h603);
                chk("left_sop0", int'(bs[0]), 1);
                chk("left_eop1", int'(be[1]), 1);
                chk("left_first_at", bc[0] - t0, 20);
            end
            clear_beats();
            t0 = cyc;
            for (int i = 0; i < 4; i++) begin
                wr_en = 1'b1; wr_data = DATA_W'('h610 + i);
                tick();
            end
            wr_en = 1'b0;
            repeat (10) tick();
            chk("fresh_beats", bd.size(), 4);
            if (bd.size() == 4) begin
                chk("fresh_data0", int'(bd[0]), 'h610);
                chk("fresh_sop0", int'(bs[0]), 1);
                chk("fresh_eop3", int'(be[3]), 1);
                chk("fresh_first_lat", bc[0] - t0, 6);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
